// File: rtl/heap_topk_stream_pkg.sv
// Shared definitions for the streaming top-K heap: entry flags, FSM states, rank compare.
// Pure declarations; no timing or flow control here.
package heap_topk_stream_pkg;

  localparam logic [1:0] FLAG_NORM = 2'b00;
  localparam logic [1:0] FLAG_MIN  = 2'b01;
  localparam logic [1:0] FLAG_MAX  = 2'b11;
  localparam int         KEY_MAX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SIFT       = 3'd1,
    ST_DRAIN      = 3'd2,
    ST_DRAIN_SIFT = 3'd3
  } state_t;

  // Sentinel that loses every insertion compare, and the one that sinks to the leaves on drain.
  function automatic logic [1:0] init_flag(input bit max_mode);
    return max_mode ? FLAG_MIN : FLAG_MAX;
  endfunction

  function automatic logic [1:0] flush_flag(input bit max_mode);
    return max_mode ? FLAG_MAX : FLAG_MIN;
  endfunction

  function automatic logic [1:0] flag_rank(input logic [1:0] f);
    case (f)
      FLAG_MIN:  return 2'd0;
      FLAG_NORM: return 2'd1;
      default:   return 2'd2;
    endcase
  endfunction

  // Strict less-than: min-sentinel < normal < max-sentinel, normals ordered by key.
  function automatic logic cmp_lt(input logic [1:0] fa, input logic [KEY_MAX_W-1:0] ka,
                                  input logic [1:0] fb, input logic [KEY_MAX_W-1:0] kb);
    logic [1:0] ra;
    logic [1:0] rb;
    ra = flag_rank(fa);
    rb = flag_rank(fb);
    if (ra != rb) return ra < rb;
    return (fa == FLAG_NORM) && (ka < kb);
  endfunction

endpackage

// File: rtl/heap_topk_stream_node_sel.sv
// Combinational sift decision for one heap node: pick the worse child, swap if it ranks below the parent.
// Zero latency; no flow control.
module heap_topk_stream_node_sel
  import heap_topk_stream_pkg::*;
#(
  parameter int KEY_WIDTH = 8,
  parameter int MAX_MODE  = 1
) (
  input  logic [1:0]           parent_flag,
  input  logic [KEY_WIDTH-1:0] parent_key,
  input  logic [1:0]           left_flag,
  input  logic [KEY_WIDTH-1:0] left_key,
  input  logic [1:0]           right_flag,
  input  logic [KEY_WIDTH-1:0] right_key,
  output logic                 swap,
  output logic                 sel_right
);

  // "worse" is smaller in MAX_MODE (min-heap) and larger otherwise (max-heap).
  function automatic logic worse(input logic [1:0] fa, input logic [KEY_WIDTH-1:0] ka,
                                 input logic [1:0] fb, input logic [KEY_WIDTH-1:0] kb);
    if (MAX_MODE != 0) return cmp_lt(fa, KEY_MAX_W'(ka), fb, KEY_MAX_W'(kb));
    return cmp_lt(fb, KEY_MAX_W'(kb), fa, KEY_MAX_W'(ka));
  endfunction

  always_comb begin
    sel_right = worse(right_flag, right_key, left_flag, left_key);
    if (sel_right) swap = worse(right_flag, right_key, parent_flag, parent_key);
    else           swap = worse(left_flag, left_key, parent_flag, parent_key);
  end

endmodule

// File: rtl/heap_topk_stream.sv
// Streaming top-K selector on a register heap; keeps the HEAP_SIZE best keys, drains them sorted on flush.
// Insert costs 1 cycle + up to NLEVELS sift cycles (in_ready low); drain beats hold until out_ready.
module heap_topk_stream
  import heap_topk_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int KEY_WIDTH  = 8,
  parameter int NLEVELS    = 2,
  parameter int MAX_MODE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NLEVELS+1:0]    count,
  output logic                  busy,
  output logic                  done
);

  localparam int HEAP_SIZE = 2 ** (NLEVELS + 1) - 1;
  localparam int IW        = NLEVELS + 1;
  localparam int CW        = NLEVELS + 2;

  typedef logic [DATA_WIDTH-1:0] entry_t;

  localparam logic [CW-1:0] HEAP_SIZE_C = CW'(HEAP_SIZE);
  localparam logic [IW-1:0] LEAF_C      = IW'(2 ** NLEVELS - 1);
  localparam logic [1:0]    INIT_F      = init_flag(MAX_MODE != 0);
  localparam logic [1:0]    FLUSH_F     = flush_flag(MAX_MODE != 0);
  localparam entry_t        INIT_ENT    = {INIT_F, {(DATA_WIDTH-2){1'b0}}};
  localparam entry_t        FLUSH_ENT   = {FLUSH_F, {(DATA_WIDTH-2){1'b0}}};

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          heap_q [HEAP_SIZE];
  entry_t          heap_d [HEAP_SIZE];

  logic [IW-1:0]   lidx, ridx, cidx;
  entry_t          par_e, l_e, r_e, root;
  logic            swap, sel_right, in_beats_root;
  state_t          back_st;

  // Leaf nodes have no children; park the child indices on the root so no lookup goes out of range.
  always_comb begin
    lidx  = (idx_q >= LEAF_C) ? '0 : {idx_q[IW-2:0], 1'b1};
    ridx  = lidx + IW'(1);
    par_e = heap_q[idx_q];
    l_e   = heap_q[lidx];
    r_e   = heap_q[ridx];
    cidx  = sel_right ? ridx : lidx;
    root  = heap_q[0];
  end

  heap_topk_stream_node_sel #(
    .KEY_WIDTH (KEY_WIDTH),
    .MAX_MODE  (MAX_MODE)
  ) u_node_sel (
    .parent_flag (par_e[DATA_WIDTH-1 -: 2]),
    .parent_key  (par_e[KEY_WIDTH-1:0]),
    .left_flag   (l_e[DATA_WIDTH-1 -: 2]),
    .left_key    (l_e[KEY_WIDTH-1:0]),
    .right_flag  (r_e[DATA_WIDTH-1 -: 2]),
    .right_key   (r_e[KEY_WIDTH-1:0]),
    .swap        (swap),
    .sel_right   (sel_right)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    heap_d    = heap_q;
    done      = 1'b0;
    out_valid = 1'b0;
    back_st   = (state_q == ST_SIFT) ? ST_IDLE : ST_DRAIN;
    in_ready  = (state_q == ST_IDLE) & ~flush & ~init & ~rst;
    if (MAX_MODE != 0)
      in_beats_root = cmp_lt(root[DATA_WIDTH-1 -: 2], KEY_MAX_W'(root[KEY_WIDTH-1:0]),
                             in_data[DATA_WIDTH-1 -: 2], KEY_MAX_W'(in_data[KEY_WIDTH-1:0]));
    else
      in_beats_root = cmp_lt(in_data[DATA_WIDTH-1 -: 2], KEY_MAX_W'(in_data[KEY_WIDTH-1:0]),
                             root[DATA_WIDTH-1 -: 2], KEY_MAX_W'(root[KEY_WIDTH-1:0]));

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (in_valid && in_ready && in_beats_root) begin
          heap_d[0] = in_data;
          idx_d     = '0;
          state_d   = ST_SIFT;
          if (root[DATA_WIDTH-1 -: 2] == INIT_F && count_q != HEAP_SIZE_C) count_d = count_q + 1'b1;
        end
      end
      ST_SIFT, ST_DRAIN_SIFT: begin
        if (swap) begin
          heap_d[idx_q] = heap_q[cidx];
          heap_d[cidx]  = heap_q[idx_q];
          idx_d         = cidx;
          if (cidx >= LEAF_C) state_d = back_st;
        end else begin
          state_d = back_st;
        end
      end
      ST_DRAIN: begin
        // count tracks normal entries exactly, so zero means only sentinels remain.
        if (count_q == '0 || root[DATA_WIDTH-1 -: 2] == FLUSH_F) begin
          done    = 1'b1;
          count_d = '0;
          state_d = ST_IDLE;
          for (int i = 0; i < HEAP_SIZE; i++) heap_d[i] = INIT_ENT;
        end else if (root[DATA_WIDTH-1 -: 2] == FLAG_NORM) begin
          out_valid = 1'b1;
          if (out_ready) begin
            heap_d[0] = FLUSH_ENT;
            count_d   = count_q - 1'b1;
            idx_d     = '0;
            state_d   = ST_DRAIN_SIFT;
          end
        end else begin
          heap_d[0] = FLUSH_ENT;
          idx_d     = '0;
          state_d   = ST_DRAIN_SIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (init) begin
      state_d   = ST_IDLE;
      count_d   = '0;
      done      = 1'b0;
      out_valid = 1'b0;
      for (int i = 0; i < HEAP_SIZE; i++) heap_d[i] = INIT_ENT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < HEAP_SIZE; i++) heap_q[i] <= INIT_ENT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      for (int i = 0; i < HEAP_SIZE; i++) heap_q[i] <= heap_d[i];
    end
  end

  assign out_data = heap_q[0];
  assign count    = count_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
